// File: rtl/stream_arb_if.sv
// Handshake bundle for stream_arb_mux: NR_CH input streams, one output stream, busy flag.
// master is the arbiter's view; slave is the view of the sources and sink around it.
interface stream_arb_if #(
  parameter int NR_CH  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
);
  logic [NR_CH-1:0]        in_valid;
  logic [NR_CH-1:0]        in_ready;
  logic [NR_CH*DATA_W-1:0] in_data;
  logic [NR_CH-1:0]        in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic [ID_W-1:0]         out_id;
  logic                    busy;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_id, busy
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_id, busy
  );
endinterface

// File: rtl/stream_arb_mux.sv
// N-channel packet arbiter/mux with a registered output stage; a grant is held
// from the first beat of a packet until its last beat is accepted.
//
// state | meaning
// IDLE  | no grant held; pick a winner among requesting channels
// BUSY  | grant held; forward beats of the granted channel until last
module stream_arb_mux #(
  parameter int NR_CH  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2,
  parameter int MODE   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  stream_arb_if.master bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   winner;
  logic [NR_CH-1:0]  in_ready_c;
  logic              load;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [ID_W-1:0]   out_id_q;

  // Search order starts at rr_ptr in round-robin mode, at channel 0 otherwise.
  always_comb begin
    int unsigned idx;
    logic        found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NR_CH; i++) begin
      if (MODE == 1) idx = (int'(rr_ptr_q) + i) % NR_CH;
      else           idx = i;
      if (!found && bus.in_valid[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    in_ready_c = '0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.in_valid) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        in_ready_c[grant_q] = ~out_valid_q | bus.out_ready;
        if (bus.in_valid[grant_q] && in_ready_c[grant_q]) begin
          load = 1'b1;
          if (bus.in_last[grant_q]) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == ID_W'(NR_CH - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // A load in the same cycle as a drain overwrites the old beat, keeping 1 beat/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data[int'(grant_q)*DATA_W +: DATA_W];
      out_last_q  <= bus.in_last[grant_q];
      out_id_q    <= grant_q;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_id    = out_id_q;
  assign bus.busy      = (state_q == BUSY);

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: a round-robin and a fixed-priority instance, each fed from
// per-channel packet queues and checked against a packet-level arbitration model.
module tb_stream_arb_mux;
  localparam int NR_CH  = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [ID_W-1:0]   id;
  } beat_t;

  typedef struct {
    int                len;
    logic [DATA_W-1:0] d [8];
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_arb_if #(.NR_CH(NR_CH), .DATA_W(DATA_W), .ID_W(ID_W)) rr_if ();
  stream_arb_if #(.NR_CH(NR_CH), .DATA_W(DATA_W), .ID_W(ID_W)) fp_if ();

  stream_arb_mux #(.NR_CH(NR_CH), .DATA_W(DATA_W), .ID_W(ID_W), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(rr_if)
  );
  stream_arb_mux #(.NR_CH(NR_CH), .DATA_W(DATA_W), .ID_W(ID_W), .MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(fp_if)
  );

  int    n_vec = 0;
  int    n_err = 0;
  int    sel = 0;
  int    rdy_pct = 100;
  int    model_ptr [2];
  beat_t src_q [NR_CH][$];
  pkt_t  pk_q [NR_CH][$];
  beat_t exp_q [$];

  logic [NR_CH-1:0]  o_in_ready, o_in_valid, fire;
  logic              o_out_valid, o_out_ready, o_out_last, o_busy, ofire;
  logic [DATA_W-1:0] o_out_data;
  logic [ID_W-1:0]   o_out_id;
  logic              hold_pend, idle_due;
  beat_t             hold_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_if();
    if (sel == 0) begin
      o_in_ready = rr_if.in_ready;   o_in_valid = rr_if.in_valid;
      o_out_valid = rr_if.out_valid; o_out_ready = rr_if.out_ready;
      o_out_data = rr_if.out_data;   o_out_last = rr_if.out_last;
      o_out_id = rr_if.out_id;       o_busy = rr_if.busy;
    end else begin
      o_in_ready = fp_if.in_ready;   o_in_valid = fp_if.in_valid;
      o_out_valid = fp_if.out_valid; o_out_ready = fp_if.out_ready;
      o_out_data = fp_if.out_data;   o_out_last = fp_if.out_last;
      o_out_id = fp_if.out_id;       o_busy = fp_if.busy;
    end
  endtask

  task automatic drive();
    logic [NR_CH-1:0]        v, l;
    logic [NR_CH*DATA_W-1:0] d;
    logic                    r;
    v = '0; l = '0; d = '0;
    for (int c = 0; c < NR_CH; c++) begin
      if (src_q[c].size() > 0) begin
        v[c] = 1'b1;
        l[c] = src_q[c][0].last;
        d[c*DATA_W +: DATA_W] = src_q[c][0].data;
      end
    end
    r = ($urandom_range(99) < rdy_pct);
    if (sel == 0) begin
      rr_if.in_valid = v; rr_if.in_last = l; rr_if.in_data = d; rr_if.out_ready = r;
      fp_if.in_valid = '0; fp_if.in_last = '0; fp_if.in_data = '0; fp_if.out_ready = 1'b1;
    end else begin
      fp_if.in_valid = v; fp_if.in_last = l; fp_if.in_data = d; fp_if.out_ready = r;
      rr_if.in_valid = '0; rr_if.in_last = '0; rr_if.in_data = '0; rr_if.out_ready = 1'b1;
    end
  endtask

  // One cycle: drive at the falling edge, sample 1ns later, retire handshakes at the next falling edge.
  task automatic step();
    beat_t e;
    drive();
    #1;
    read_if();
    fire  = o_in_valid & o_in_ready;
    ofire = o_out_valid & o_out_ready;
    chk("in_ready_onehot", ($countones(o_in_ready) <= 1), 1);
    if (idle_due) chk("idle_after_last", o_busy, 0);
    if (hold_pend) begin
      chk("hold_valid", o_out_valid, 1);
      chk("hold_data", o_out_data, hold_b.data);
      chk("hold_last", o_out_last, hold_b.last);
      chk("hold_id", o_out_id, hold_b.id);
    end
    hold_pend = o_out_valid & ~o_out_ready;
    hold_b.data = o_out_data; hold_b.last = o_out_last; hold_b.id = o_out_id;
    idle_due = 1'b0;
    for (int c = 0; c < NR_CH; c++)
      if (fire[c] && src_q[c][0].last) idle_due = 1'b1;
    if (ofire) begin
      if (exp_q.size() == 0) chk("spurious_beat", ofire, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", o_out_data, e.data);
        chk("out_last", o_out_last, e.last);
        chk("out_id", o_out_id, e.id);
      end
    end
    @(negedge clk);
    for (int c = 0; c < NR_CH; c++)
      if (fire[c]) void'(src_q[c].pop_front());
  endtask

  function automatic bit srcs_pending();
    for (int c = 0; c < NR_CH; c++)
      if (src_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_pkt(input int ch, input int len, input logic [DATA_W-1:0] base, input bit rnd);
    pkt_t  p;
    beat_t b;
    p.len = len;
    for (int i = 0; i < 8; i++) p.d[i] = '0;
    for (int i = 0; i < len; i++) begin
      p.d[i] = rnd ? DATA_W'($urandom) : base + DATA_W'(i);
      b.data = p.d[i]; b.last = (i == len - 1); b.id = ID_W'(ch);
      src_q[ch].push_back(b);
    end
    pk_q[ch].push_back(p);
  endtask

  // Every pending channel is backlogged, so packet order follows from the arbitration rule alone.
  task automatic schedule(input int mode);
    int    w;
    pkt_t  p;
    beat_t b;
    do begin
      w = -1;
      for (int i = 0; i < NR_CH; i++) begin
        int c;
        c = (mode == 1) ? (model_ptr[sel] + i) % NR_CH : i;
        if (w < 0 && pk_q[c].size() > 0) w = c;
      end
      if (w >= 0) begin
        p = pk_q[w].pop_front();
        for (int i = 0; i < p.len; i++) begin
          b.data = p.d[i]; b.last = (i == p.len - 1); b.id = ID_W'(w);
          exp_q.push_back(b);
        end
        model_ptr[sel] = (w + 1) % NR_CH;
      end
    end while (w >= 0);
  endtask

  task automatic run(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || srcs_pending()) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    step();
  endtask

  task automatic clear_model();
    for (int c = 0; c < NR_CH; c++) begin
      src_q[c].delete();
      pk_q[c].delete();
    end
    exp_q.delete();
    model_ptr[0] = 0; model_ptr[1] = 0;
    hold_pend = 1'b0; idle_due = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    int s;
    s = sel;
    for (int k = 0; k < 2; k++) begin
      sel = k;
      read_if();
      chk({tag, "_out_valid"}, o_out_valid, 0);
      chk({tag, "_out_data"}, o_out_data, 0);
      chk({tag, "_out_last"}, o_out_last, 0);
      chk({tag, "_out_id"}, o_out_id, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_in_ready"}, o_in_ready, 0);
    end
    sel = s;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sel = 0;
    clear_model();
    drive();
    rst_n = 1'b0;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      step();
      chk("idle_out_valid", o_out_valid, 0);
      chk("idle_in_ready", o_in_ready, 0);
      chk("idle_busy", o_busy, 0);
    end

    // Round-robin over single-beat packets: ids 0,1,2,3,0,...
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NR_CH; c++) add_pkt(c, 1, 32'hA0 + DATA_W'(c), 1'b0);
    schedule(1);
    run("rr_single", 100);

    // Output back-pressure: stall 3 cycles with a beat held, then expect back-to-back drain.
    add_pkt(1, 6, 32'h50, 1'b0);
    schedule(1);
    rdy_pct = 0;
    n = 0;
    while (!o_out_valid && n < 10) begin step(); n++; end
    chk("bp_out_valid_seen", o_out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_in_ready", o_in_ready, 0);
      chk("bp_out_valid", o_out_valid, 1);
    end
    rdy_pct = 100;
    n = 0;
    while (exp_q.size() > 0 && n < 12) begin
      step();
      chk("b2b_out_fire", ofire, 1);
      n++;
    end
    run("bp", 10);

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NR_CH; c++) begin
        int np;
        np = $urandom_range(3);
        for (int p = 0; p < np; p++) add_pkt(c, $urandom_range(1, 4), '0, 1'b1);
      end
      schedule(1);
      rdy_pct = 70;
      run("rr_rand", 400);
      rdy_pct = 100;
    end

    // Fixed priority: channel 1 always beats channel 2.
    sel = 1;
    for (int k = 0; k < 4; k++) begin
      add_pkt(1, 1, 32'hB1, 1'b0);
      add_pkt(2, 1, 32'hB2, 1'b0);
    end
    schedule(0);
    run("fp_pri", 100);

    // Grant hold: channel 2 keeps the grant over a later channel 0 request.
    add_pkt(2, 4, 32'h10, 1'b0);
    schedule(0);
    n = 0;
    while (!o_busy && n < 5) begin step(); n++; end
    chk("hold_busy_seen", o_busy, 1);
    add_pkt(0, 1, 32'h77, 1'b0);
    schedule(0);
    run("fp_hold", 50);

    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NR_CH; c++) begin
        int np;
        np = $urandom_range(3);
        for (int p = 0; p < np; p++) add_pkt(c, $urandom_range(1, 4), '0, 1'b1);
      end
      schedule(0);
      rdy_pct = 70;
      run("fp_rand", 400);
      rdy_pct = 100;
    end

    // Asynchronous reset mid-packet, away from any rising edge.
    sel = 0;
    add_pkt(3, 5, 32'hC0, 1'b0);
    schedule(1);
    rdy_pct = 0;
    n = 0;
    while (!o_out_valid && n < 10) begin step(); n++; end
    chk("mid_rst_out_valid_before", o_out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    read_if();
    chk("async_rst_out_valid", o_out_valid, 0);
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_in_ready", o_in_ready, 0);
    clear_model();
    rdy_pct = 100;
    @(negedge clk);
    rst_n = 1'b1;
    add_pkt(2, 1, 32'hD2, 1'b0);
    schedule(1);
    run("post_rst", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
- Parametrised N-channel stream arbiter and multiplexer with a valid/ready handshake on every port and a registered output stage.
- Successor to the combinational key/value mux: it selects one of NR_CH input streams and holds that grant for a whole packet, which ends on a beat with last=1.
- Used wherever several NPC requesters (IFU, LSU, debug) share one bus master port.

Parameters:
- NR_CH, 4: number of input channels; legal range 2..16.
- DATA_W, 32: payload width per channel.
- ID_W, 2: width of out_id; must equal clog2(NR_CH).
- MODE, 1: arbitration mode. 0 = fixed priority (channel 0 highest). 1 = round-robin.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NR_CH  per-channel valid.
- in_ready  output  NR_CH  per-channel ready.
- in_data  input  NR_CH*DATA_W  channel n payload in bits [DATA_W*(n+1)-1 : DATA_W*n].
- in_last  input  NR_CH  per-channel end-of-packet flag.
- out_valid  output  1  output beat valid (registered).
- out_ready  input  1  downstream ready.
- out_data  output  DATA_W  registered payload.
- out_last  output  1  registered end-of-packet flag.
- out_id  output  ID_W  channel index of the current out_data.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_last=0, out_id=0, busy=0.
  - State IDLE; grant=0; rr_ptr=0.
  - in_ready=0 for all channels.
  - Reset asserted mid-packet drops the in-flight beat; no flush is attempted.
- Handshake:
  - A transfer occurs on a cycle with valid & ready.
  - Sources must hold data and last stable while valid=1 and ready=0. The block does not check this.
- State machine with states IDLE and BUSY:
  - IDLE: all in_ready=0. If any in_valid=1, compute winner g and go to BUSY next cycle with grant=g and busy=1. Otherwise stay in IDLE.
  - BUSY: in_ready[grant] = (~out_valid | out_ready); all other in_ready=0.
  - BUSY, input transfer on the granted channel: the output register loads in_data[grant], in_last[grant] and out_id=grant; out_valid is set to 1 on the next edge.
  - BUSY, input transfer with in_last=1: return to IDLE next cycle, busy=0, rr_ptr = (grant+1) mod NR_CH.
- Output register:
  - If out_valid & out_ready and no new load, out_valid goes to 0.
  - Simultaneous output drain and input load: the new beat replaces the old one, giving full throughput of 1 beat/cycle within a packet.
- Latency and overhead:
  - 1 cycle from input acceptance to out_valid.
  - Arbitration costs 1 idle cycle per packet (the IDLE cycle).
- Arbitration:
  - MODE 0: g = lowest index with in_valid=1.
  - MODE 1: g = first index with in_valid=1 searching from rr_ptr upward and wrapping. Example: NR_CH=4, rr_ptr=3 searches 3,0,1,2.
  - rr_ptr changes only at end of packet.
- Grant hold:
  - The grant holds regardless of requests on other channels.
  - If the granted in_valid drops mid-packet, the block waits in BUSY indefinitely; there is no timeout.
- Packet length:
  - A single-beat packet (last=1 on its first beat) passes IDLE -> BUSY -> IDLE, so the next grant can be decided on the cycle after it returns to IDLE.
- Output hold:
  - out_data, out_last and out_id stay stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset release, all in_valid=0 for 5 cycles: out_valid=0, in_ready=0, busy=0 throughout. Assert rst_n=0 mid-packet: out_valid falls to 0 without waiting for a clock edge.
- MODE=1, NR_CH=4, channels 0..3 each send one single-beat packet continuously (data = 0xA0+ch): out_id sequence 0,1,2,3,0; out_data 0xA0,0xA1,0xA2,0xA3,0xA0.
- MODE=0, channels 1 and 2 always valid, single-beat packets: out_id is always 1 and channel 2 is never granted.
- Channel 2 sends a 4-beat packet 0x10..0x13 with last on beat 4, while channel 0 requests from cycle 1: out_data 0x10,0x11,0x12,0x13 all with out_id=2. Channel 0 is granted only after the IDLE cycle that follows.
- out_ready held 0 for 3 cycles while out_valid=1: out_data is stable and in_ready[grant]=0. When out_ready rises, beats resume back-to-back, 1 per cycle, with no loss or duplication.
